// File: rtl/pkg_dfm_arb.sv
// Shared types and constants for the DFM bus arbiter.
package pkg_dfm_arb;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Requester identities
    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_t;

    // Upper address nibble that selects the DFM region
    localparam logic [3:0] DFM_REGION = 4'b0001;

endpackage

// File: rtl/dfm_arb_priority.sv
// Grant selection between CPU and DMA: CPU has fixed priority, except when
// the DMA has lost STARVE_LIMIT consecutive arbitrations.
module dfm_arb_priority #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic idle,
    input  logic cpu_valid,
    input  logic dma_valid,
    output logic cpu_ready,
    output logic dma_ready
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] dma_wait_cnt_reg;
    logic       grant_dma;

    // DMA wins when alone, or when it has waited long enough
    always_comb begin
        grant_dma = dma_valid && (!cpu_valid || (dma_wait_cnt_reg >= LIMIT));
        cpu_ready = idle && cpu_valid && !grant_dma;
        dma_ready = idle && grant_dma;
    end

    // Count CPU wins while DMA is waiting; cleared when DMA is served
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            dma_wait_cnt_reg <= 4'd0;
        end else if (dma_ready) begin
            dma_wait_cnt_reg <= 4'd0;
        end else if (cpu_ready && dma_valid && (dma_wait_cnt_reg < LIMIT)) begin
            dma_wait_cnt_reg <= dma_wait_cnt_reg + 4'd1;
        end
    end

endmodule

// File: rtl/dfm_bus_arbiter.sv
// Two-requester arbiter and single-beat access sequencer for the data flash
// memory. One access in flight at a time: IDLE -> ACCESS -> RESP.
module dfm_bus_arbiter
    import pkg_dfm_arb::*;
#(
    parameter int ADDR_BUS_WIDTH = 32,
    parameter int DATA_BUS_WIDTH = 32,
    parameter int DFM_ADDR_WIDTH = 10,
    parameter int STARVE_LIMIT   = 3
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      cpu_req_valid,
    output logic                      cpu_req_ready,
    input  logic [ADDR_BUS_WIDTH-1:0] cpu_req_addr,
    input  logic                      cpu_wr_en,
    input  logic [DATA_BUS_WIDTH-1:0] cpu_wr_data,
    output logic                      cpu_rsp_valid,
    output logic                      cpu_rsp_err,
    output logic [DATA_BUS_WIDTH-1:0] cpu_rd_data,
    input  logic                      dma_req_valid,
    output logic                      dma_req_ready,
    input  logic [ADDR_BUS_WIDTH-1:0] dma_req_addr,
    input  logic                      dma_wr_en,
    input  logic [DATA_BUS_WIDTH-1:0] dma_wr_data,
    output logic                      dma_rsp_valid,
    output logic                      dma_rsp_err,
    output logic [DATA_BUS_WIDTH-1:0] dma_rd_data,
    output logic                      dfm_en,
    output logic                      dfm_wr_en,
    output logic [DFM_ADDR_WIDTH-1:0] dfm_addr,
    output logic [DATA_BUS_WIDTH-1:0] dfm_wr_data,
    input  logic [DATA_BUS_WIDTH-1:0] dfm_rd_data
);

    state_t  state_reg;
    req_id_t owner_reg;
    logic    err_reg;
    logic    rd_reg;

    logic                      accept;
    logic [ADDR_BUS_WIDTH-1:0] sel_addr;
    logic                      sel_wr;
    logic [DATA_BUS_WIDTH-1:0] sel_wr_data;
    logic                      in_region;
    logic                      in_resp;
    logic [DATA_BUS_WIDTH-1:0] rsp_data;
    logic                      unused_addr_bits;

    dfm_arb_priority #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_priority (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .idle      (state_reg == IDLE),
        .cpu_valid (cpu_req_valid),
        .dma_valid (dma_req_valid),
        .cpu_ready (cpu_req_ready),
        .dma_ready (dma_req_ready)
    );

    // Route the granted requester's fields and decode its region
    always_comb begin
        accept      = cpu_req_ready || dma_req_ready;
        sel_addr    = dma_req_ready ? dma_req_addr : cpu_req_addr;
        sel_wr      = dma_req_ready ? dma_wr_en    : cpu_wr_en;
        sel_wr_data = dma_req_ready ? dma_wr_data  : cpu_wr_data;
        in_region   = (sel_addr[ADDR_BUS_WIDTH-1 -: 4] == DFM_REGION);
    end

    // Byte offset and the gap between region nibble and word address are don't-care
    assign unused_addr_bits = ^{sel_addr[ADDR_BUS_WIDTH-5:DFM_ADDR_WIDTH+2], sel_addr[1:0]};

    // Access sequencer: latch the accepted request, strobe DFM for one cycle, respond
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg   <= IDLE;
            owner_reg   <= REQ_CPU;
            err_reg     <= 1'b0;
            rd_reg      <= 1'b0;
            dfm_en      <= 1'b0;
            dfm_wr_en   <= 1'b0;
            dfm_addr    <= '0;
            dfm_wr_data <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg   <= ACCESS;
                        owner_reg   <= dma_req_ready ? REQ_DMA : REQ_CPU;
                        err_reg     <= !in_region;
                        rd_reg      <= !sel_wr;
                        dfm_en      <= in_region;
                        dfm_wr_en   <= sel_wr && in_region;
                        dfm_addr    <= sel_addr[DFM_ADDR_WIDTH+1:2];
                        dfm_wr_data <= sel_wr_data;
                    end
                end
                ACCESS: begin
                    state_reg <= RESP;
                    dfm_en    <= 1'b0;
                    dfm_wr_en <= 1'b0;
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Steer the response to the owner only; reads of in-region words carry DFM data
    always_comb begin
        in_resp       = (state_reg == RESP);
        rsp_data      = (rd_reg && !err_reg) ? dfm_rd_data : '0;
        cpu_rsp_valid = in_resp && (owner_reg == REQ_CPU);
        dma_rsp_valid = in_resp && (owner_reg == REQ_DMA);
        cpu_rsp_err   = cpu_rsp_valid && err_reg;
        dma_rsp_err   = dma_rsp_valid && err_reg;
        cpu_rd_data   = cpu_rsp_valid ? rsp_data : '0;
        dma_rd_data   = dma_rsp_valid ? rsp_data : '0;
    end

endmodule

// File: tb/tb_dfm_bus_arbiter.sv
// Directed bench for dfm_bus_arbiter with a behavioural synchronous DFM.
module tb_dfm_bus_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        cpu_req_valid = 1'b0, dma_req_valid = 1'b0;
    logic        cpu_req_ready, dma_req_ready;
    logic [31:0] cpu_req_addr = '0, dma_req_addr = '0;
    logic        cpu_wr_en = 1'b0, dma_wr_en = 1'b0;
    logic [31:0] cpu_wr_data = '0, dma_wr_data = '0;
    logic        cpu_rsp_valid, dma_rsp_valid, cpu_rsp_err, dma_rsp_err;
    logic [31:0] cpu_rd_data, dma_rd_data;
    logic        dfm_en, dfm_wr_en;
    logic [9:0]  dfm_addr;
    logic [31:0] dfm_wr_data, dfm_rd_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] mem [0:1023];

    dfm_bus_arbiter #(
        .ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32), .DFM_ADDR_WIDTH(10), .STARVE_LIMIT(3)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_addr(cpu_req_addr), .cpu_wr_en(cpu_wr_en), .cpu_wr_data(cpu_wr_data),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_err(cpu_rsp_err), .cpu_rd_data(cpu_rd_data),
        .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
        .dma_req_addr(dma_req_addr), .dma_wr_en(dma_wr_en), .dma_wr_data(dma_wr_data),
        .dma_rsp_valid(dma_rsp_valid), .dma_rsp_err(dma_rsp_err), .dma_rd_data(dma_rd_data),
        .dfm_en(dfm_en), .dfm_wr_en(dfm_wr_en), .dfm_addr(dfm_addr),
        .dfm_wr_data(dfm_wr_data), .dfm_rd_data(dfm_rd_data)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Synchronous single-port memory: read data one cycle after dfm_en
    always @(posedge sys_clk) begin
        if (dfm_en) begin
            if (dfm_wr_en) mem[dfm_addr] <= dfm_wr_data;
            dfm_rd_data <= mem[dfm_addr];
        end
    end

    always @(negedge sys_clk)
        assert (!(cpu_req_ready && dma_req_ready)) else $error("FAIL both_ready asserted together");

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete request/response through one port
    task automatic do_req(input bit is_dma, input logic [31:0] addr, input bit wr,
                          input logic [31:0] wdata, input bit exp_err,
                          input logic [31:0] exp_rd, input logic [9:0] exp_waddr);
        bit got = 0;
        @(negedge sys_clk);
        if (is_dma) begin
            dma_req_valid = 1; dma_req_addr = addr; dma_wr_en = wr; dma_wr_data = wdata;
        end else begin
            cpu_req_valid = 1; cpu_req_addr = addr; cpu_wr_en = wr; cpu_wr_data = wdata;
        end
        for (int k = 0; k < 20; k++) begin
            #1;
            if (is_dma ? dma_req_ready : cpu_req_ready) begin got = 1; break; end
            @(negedge sys_clk);
        end
        check("accept", 32'(got), 32'd1);
        check("other_ready", 32'(is_dma ? cpu_req_ready : dma_req_ready), 32'd0);
        @(negedge sys_clk);
        cpu_req_valid = 0; dma_req_valid = 0;
        check("dfm_en", 32'(dfm_en), 32'(!exp_err));
        check("dfm_wr_en", 32'(dfm_wr_en), 32'(wr && !exp_err));
        if (!exp_err) check("dfm_addr", 32'(dfm_addr), 32'(exp_waddr));
        if (wr && !exp_err) check("dfm_wr_data", dfm_wr_data, wdata);
        check("early_rsp", 32'(cpu_rsp_valid | dma_rsp_valid), 32'd0);
        @(negedge sys_clk);
        check("rsp_valid", 32'(is_dma ? dma_rsp_valid : cpu_rsp_valid), 32'd1);
        check("rsp_err", 32'(is_dma ? dma_rsp_err : cpu_rsp_err), 32'(exp_err));
        check("rd_data", is_dma ? dma_rd_data : cpu_rd_data, exp_rd);
        check("other_rsp", 32'(is_dma ? cpu_rsp_valid : dma_rsp_valid), 32'd0);
        check("other_rd_data", is_dma ? cpu_rd_data : dma_rd_data, 32'd0);
        $display("txn %s %s addr=0x%08h wdata=0x%08h rdata=0x%08h err=%0d",
                 is_dma ? "DMA" : "CPU", wr ? "WR" : "RD", addr, wdata,
                 is_dma ? dma_rd_data : cpu_rd_data, is_dma ? dma_rsp_err : cpu_rsp_err);
        @(negedge sys_clk);
        check("rsp_pulse_end", 32'(cpu_rsp_valid | dma_rsp_valid), 32'd0);
    endtask

    // Hold the given valids for n grants; bit g of pattern = 1 means DMA expected
    task automatic grant_seq(input bit cpu_v, input bit dma_v, input int n, input logic [15:0] pattern);
        int last_cyc = 0;
        @(negedge sys_clk);
        cpu_req_valid = cpu_v; cpu_req_addr = 32'h1000_0000; cpu_wr_en = 0;
        dma_req_valid = dma_v; dma_req_addr = 32'h1000_0004; dma_wr_en = 0;
        for (int g = 0; g < n; g++) begin
            bit got = 0;
            for (int k = 0; k < 20; k++) begin
                #1;
                if (cpu_req_ready || dma_req_ready) begin got = 1; break; end
                @(negedge sys_clk);
            end
            check("grant_timeout", 32'(got), 32'd1);
            check("both_ready", 32'(cpu_req_ready && dma_req_ready), 32'd0);
            check("grant_dma", 32'(dma_req_ready), 32'(pattern[g]));
            if (g > 0) check("ready_spacing", 32'(cyc - last_cyc), 32'd3);
            last_cyc = cyc;
            $display("txn grant %0d to %s at cycle %0d", g, dma_req_ready ? "DMA" : "CPU", cyc);
            @(negedge sys_clk);
        end
        cpu_req_valid = 0; dma_req_valid = 0;
        repeat (3) @(negedge sys_clk);
    endtask

    initial begin
        #1;
        check("rst_cpu_ready", 32'(cpu_req_ready), 32'd0);
        check("rst_dfm_en", 32'(dfm_en), 32'd0);
        check("rst_dfm_wr_en", 32'(dfm_wr_en), 32'd0);
        check("rst_dfm_addr", 32'(dfm_addr), 32'd0);
        check("rst_dfm_wr_data", dfm_wr_data, 32'd0);
        check("rst_rsp", 32'(cpu_rsp_valid | dma_rsp_valid | cpu_rsp_err | dma_rsp_err), 32'd0);
        repeat (2) @(negedge sys_clk);
        sys_rst = 0;

        // CPU write then read back, word 4
        do_req(0, 32'h1000_0010, 1, 32'hDEAD_BEEF, 0, 32'h0, 10'd4);
        do_req(0, 32'h1000_0010, 0, 32'h0, 0, 32'hDEAD_BEEF, 10'd4);
        // Out-of-region read
        do_req(0, 32'h2000_0000, 0, 32'h0, 1, 32'h0, 10'd0);
        // Out-of-region write with ignored byte offset
        do_req(1, 32'h0000_0013, 1, 32'h5555_AAAA, 1, 32'h0, 10'd0);
        // DMA alone at the top word, address bits 27:12 and 1:0 ignored
        do_req(1, 32'h1ABC_DFFC, 1, 32'h1234_5678, 0, 32'h0, 10'd1023);
        do_req(1, 32'h1000_0FFC, 0, 32'h0, 0, 32'h1234_5678, 10'd1023);

        // Reset during ACCESS of a write
        do_req(0, 32'h1000_0020, 1, 32'h1111_1111, 0, 32'h0, 10'd8);
        begin
            bit got = 0;
            @(negedge sys_clk);
            cpu_req_valid = 1; cpu_req_addr = 32'h1000_0020; cpu_wr_en = 1; cpu_wr_data = 32'h2222_2222;
            for (int k = 0; k < 20; k++) begin
                #1;
                if (cpu_req_ready) begin got = 1; break; end
                @(negedge sys_clk);
            end
            check("rst_accept", 32'(got), 32'd1);
            @(negedge sys_clk);
            cpu_req_valid = 0;
            check("rst_pre_dfm_en", 32'(dfm_en), 32'd1);
            #2 sys_rst = 1;
            #1;
            check("rst_async_dfm_en", 32'(dfm_en), 32'd0);
            check("rst_async_dfm_wr_en", 32'(dfm_wr_en), 32'd0);
            @(negedge sys_clk);
            sys_rst = 0;
            for (int k = 0; k < 3; k++) begin
                @(negedge sys_clk);
                check("rst_no_rsp", 32'(cpu_rsp_valid), 32'd0);
            end
            $display("txn CPU WR addr=0x10000020 aborted by reset");
        end
        do_req(0, 32'h1000_0020, 0, 32'h0, 0, 32'h1111_1111, 10'd8);

        // Back-to-back CPU only: spacing 3
        grant_seq(1, 0, 3, 16'h0000);
        // Both continuously valid: CPU, CPU, CPU, DMA, repeating
        grant_seq(1, 1, 8, 16'h0088);
        // Saturate counter, then CPU alone keeps winning, then DMA wins at once
        grant_seq(1, 1, 3, 16'h0000);
        grant_seq(1, 0, 2, 16'h0000);
        grant_seq(1, 1, 2, 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
